// File: rtl/bsg_popcount.sv
// ============================================================================
// Module   : bsg_popcount
// Brief    : Combinational population count of a width_p-bit word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_popcount #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0]         data_i,
    output logic [$clog2(width_p+1)-1:0] count_o
);

    localparam int cnt_width_lp = $clog2(width_p + 1);

    // Count is sized to hold width_p itself, so an all-ones word never wraps.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < width_p; i++) begin
            count_o = count_o + cnt_width_lp'(data_i[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_dbi_encoder.sv
// ============================================================================
// Module   : bsg_dbi_encoder
// Brief    : Data-bus-inversion encoder with a one-entry valid/yumi output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_dbi_encoder #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               inv_o,
    input  logic               yumi_i
);

    localparam int                    cnt_width_lp = $clog2(width_p + 1);
    localparam logic [cnt_width_lp-1:0] half_lp    = cnt_width_lp'(width_p / 2);

    logic               v_q,    v_d;
    logic [width_p-1:0] data_q, data_d;
    logic               inv_q,  inv_d;

    logic [width_p-1:0]      last_r;
    logic [width_p-1:0]      diff;
    logic [cnt_width_lp-1:0] toggles;
    logic                    invert;
    logic                    in_xfer;
    logic                    out_xfer;

    // The output register always holds the most recent encoding, even after
    // it has been consumed, so it doubles as the comparison history.
    assign last_r = data_q;
    assign diff   = data_i ^ last_r;

    bsg_popcount #(
        .width_p (width_p)
    ) u_popcount (
        .data_i  (diff),
        .count_o (toggles)
    );

    // Strictly greater: a tie keeps the raw word.
    assign invert   = (toggles > half_lp);

    assign ready_o  = ~v_q | yumi_i;
    assign in_xfer  = v_i & ready_o;
    assign out_xfer = v_q & yumi_i;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        inv_d  = inv_q;
        if (in_xfer) begin
            v_d    = 1'b1;
            data_d = invert ? ~data_i : data_i;
            inv_d  = invert;
        end else if (out_xfer) begin
            v_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            inv_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            inv_q  <= inv_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign inv_o  = inv_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_dbi_encoder.sv
// ============================================================================
// Module   : tb_bsg_dbi_encoder
// Brief    : Scoreboard bench for bsg_dbi_encoder at width_p = 16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_dbi_encoder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] raw;
        logic [W-1:0] enc;
        logic         inv;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         inv_o;
    logic         yumi_i;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_pops   = 0;
    logic         chk_toggle = 1'b0;
    logic [W-1:0] prev_out   = '0;
    logic [W-1:0] m_last     = '0;

    bsg_dbi_encoder #(.width_p(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .inv_o   (inv_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference encoding from the bench's own history register.
    task automatic model_push(input logic [W-1:0] w);
        exp_t e;
        e.raw = w;
        e.inv = ($countones(w ^ m_last) > W / 2);
        e.enc = e.inv ? ~w : w;
        m_last = e.enc;
        sb_q.push_back(e);
    endtask

    // Monitor: every output transfer pops one expectation.
    always @(negedge clk_i) begin
        if (!reset_i && v_o && yumi_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'(data_o), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_pops++;
                check("data_o", 32'(data_o), 32'(e.enc));
                check("inv_o", 32'(inv_o), 32'(e.inv));
                check("decode", 32'(data_o ^ {W{inv_o}}), 32'(e.raw));
                if (chk_toggle)
                    check("toggle_le_half", 32'($countones(data_o ^ prev_out) <= W / 2), 32'd1);
                prev_out = data_o;
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        data_i  = '0;
        yumi_i  = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        @(negedge clk_i);
        check("reset_v_o", 32'(v_o), 32'd0);
        check("reset_data_o", 32'(data_o), 32'd0);
        check("reset_inv_o", 32'(inv_o), 32'd0);
        check("reset_ready_o", 32'(ready_o), 32'd1);
        tick();

        // Directed encodings with hand-computed results.
        yumi_i = 1'b1;
        v_i = 1'b1; data_i = 16'hFFFF;
        sb_q.push_back('{raw: 16'hFFFF, enc: 16'h0000, inv: 1'b1});
        tick();
        data_i = 16'h00FF;
        sb_q.push_back('{raw: 16'h00FF, enc: 16'h00FF, inv: 1'b0});
        tick();
        data_i = 16'hFF01;
        sb_q.push_back('{raw: 16'hFF01, enc: 16'h00FE, inv: 1'b1});
        tick();
        v_i = 1'b0;
        tick();
        check("drain_v_o", 32'(v_o), 32'd0);

        // Backpressure: 0x1234 vs 0x00FE flips 6 bits, then 0xEDCB flips all 16.
        yumi_i = 1'b0;
        v_i = 1'b1; data_i = 16'h1234;
        sb_q.push_back('{raw: 16'h1234, enc: 16'h1234, inv: 1'b0});
        tick();
        data_i = 16'hEDCB;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_ready_o", 32'(ready_o), 32'd0);
            check("bp_data_o", 32'(data_o), 32'h1234);
            check("bp_inv_o", 32'(inv_o), 32'd0);
            tick();
        end
        yumi_i = 1'b1;
        sb_q.push_back('{raw: 16'hEDCB, enc: 16'h1234, inv: 1'b1});
        tick();
        v_i = 1'b0;
        tick();
        m_last = 16'h1234;

        // Streaming random words at full rate.
        chk_toggle = 1'b1;
        prev_out   = 16'h1234;
        n_pops     = 0;
        v_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data_i = W'($urandom);
            model_push(data_i);
            @(negedge clk_i);
            check("stream_ready_o", 32'(ready_o), 32'd1);
            tick();
        end
        v_i = 1'b0;
        tick();
        chk_toggle = 1'b0;
        check("stream_count", 32'(n_pops), 32'd100);

        // Reset while a word is held: it must vanish without a transfer.
        yumi_i = 1'b0;
        v_i = 1'b1; data_i = 16'h5555;
        tick();
        reset_i = 1'b1; yumi_i = 1'b1; v_i = 1'b1; data_i = 16'h0F0F;
        tick();
        reset_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_v_o", 32'(v_o), 32'd0);
        check("rst_mid_data_o", 32'(data_o), 32'd0);
        tick();
        yumi_i = 1'b1;
        v_i = 1'b1; data_i = 16'hFFFF;
        sb_q.push_back('{raw: 16'hFFFF, enc: 16'h0000, inv: 1'b1});
        tick();
        v_i = 1'b0;
        tick();
        tick();

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bsg_dbi_encoder.md
BSG_DBI_ENCODER -- requirements
Module: bsg_dbi_encoder

Interface
REQ-001 The module SHALL have parameter width_p, default 16, giving the data word width in bits; legal values are even and at least 2.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_i, input, 1 bit: reset, which is synchronous and active-high.
REQ-004 The module SHALL have port v_i, input, 1 bit: the input word is valid.
REQ-005 The module SHALL have port data_i, input, width_p bits: the raw input word.
REQ-006 The module SHALL have port ready_o, output, 1 bit: the block can accept a word this cycle.
REQ-007 The module SHALL have port v_o, output, 1 bit: an encoded word is held at the output.
REQ-008 The module SHALL have port data_o, output, width_p bits: the encoded word, raw or bitwise-inverted.
REQ-009 The module SHALL have port inv_o, output, 1 bit: the word on data_o is inverted; the receiver inverts it back.
REQ-010 The module SHALL have port yumi_i, input, 1 bit: the consumer takes data_o this cycle; legal only when v_o=1.

Function
REQ-011 An input transfer SHALL occur when v_i & ready_o; an output transfer SHALL occur when v_o & yumi_i.
REQ-012 ready_o SHALL equal ~v_o | yumi_i, so that with continuous yumi_i the block accepts one word per cycle with no bubble.
REQ-013 The block SHALL hold a register last_r: the encoded word of the most recently accepted input.
- Reset value of last_r is all zeros.
- last_r equals data_o whenever v_o=1.
REQ-014 On an input transfer, the block SHALL compute t = popcount(data_i ^ last_r) using combinational logic.
REQ-015 If t > width_p/2, the accepted encoding SHALL be ~data_i with inv=1; otherwise it SHALL be data_i with inv=0.
- At t == width_p/2 exactly, the word is not inverted.
REQ-016 On an input transfer, data_o, inv_o and last_r SHALL load the encoding, and v_o SHALL be 1 in the next cycle.
- Latency from input to output is one cycle.
REQ-017 On an output transfer with no simultaneous input transfer, v_o SHALL go 0 in the next cycle.
- data_o, inv_o and last_r keep their values.
REQ-018 On simultaneous input and output transfers, the block SHALL take the new encoding, and v_o SHALL stay 1.
REQ-019 While v_o=1 and yumi_i=0, data_o and inv_o SHALL remain stable and ready_o SHALL be 0.
REQ-020 The popcount threshold SHALL be computed at a width of clog2(width_p+1) bits with no truncation.
REQ-021 When v_i=0, no state SHALL change except as caused by an output transfer.

Reset
REQ-022 While reset_i=1 at a clock edge, the next state SHALL be: v_o=0, data_o=0, inv_o=0, last_r=0.
- ready_o=1 combinationally once v_o=0.
REQ-023 A reset asserted mid-operation SHALL discard any held word without an output transfer.
- Encoding after reset restarts from last_r=0.
REQ-024 v_i and yumi_i SHALL be ignored in any cycle in which reset_i=1.

Structure
REQ-025 No shared package SHALL be required; width_p is the only configuration item.
REQ-026 The population count SHALL be implemented in one sub-module, bsg_popcount, with parameter width_p.
- Everything else is flat in this module.
REQ-027 The RTL SHALL be fully synchronous, with no latches and no combinational path from yumi_i to data_o.

Verification (width_p=16)
REQ-028 Reset, then input 0xFFFF -> next cycle: v_o=1, data_o=0x0000, inv_o=1 (t=16).
REQ-029 Following input 0x00FF against last_r=0x0000 -> data_o=0x00FF, inv_o=0 (t=8, tie does not invert).
REQ-030 Following input 0xFF01 against last_r=0x00FF -> data_o=0x00FE, inv_o=1 (t=15).
REQ-031 Backpressure: hold yumi_i=0 for 5 cycles with v_i=1 -> ready_o=0 and data_o/inv_o stable.
- On the yumi_i=1 cycle, the new word is accepted in the same cycle.
REQ-032 Streaming: v_i=1 and yumi_i=1 every cycle for 100 random words -> one output per cycle, in order.
- Decoding (data_o ^ {16{inv_o}}) reproduces every input exactly.
- Each output word toggles at most 8 bits versus the previous one.
REQ-033 Assert reset_i for one cycle while v_o=1 -> v_o=0 next cycle, the held word is lost.
- Then input 0xFFFF -> data_o=0x0000, inv_o=1.
